// File: rtl/can_tx_frame_serializer_if.sv
// rtl/can_tx_frame_serializer_if.sv - unstuffed CAN frame bit stream handshake
interface can_tx_frame_serializer_if;
  logic tx_bit;
  logic bit_valid;
  logic bit_ready;
  logic in_arbitration;

  modport master (
    output tx_bit,
    output bit_valid,
    output in_arbitration,
    input  bit_ready
  );

  modport slave (
    input  tx_bit,
    input  bit_valid,
    input  in_arbitration,
    output bit_ready
  );
endinterface

// File: rtl/can_tx_frame_serializer.sv
// rtl/can_tx_frame_serializer.sv - TX buffer snapshot to unstuffed CAN bit stream with CRC-15
module can_tx_frame_serializer #(
  parameter int          DATA_MAX = 8,
  parameter logic [14:0] CRC_POLY = 15'h4599
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             extended_mode,
  input  logic                             tx_request,
  input  logic                             abort_tx,
  input  logic [7:0]                       tx_data_0,
  input  logic [7:0]                       tx_data_1,
  input  logic [7:0]                       tx_data_2,
  input  logic [7:0]                       tx_data_3,
  input  logic [7:0]                       tx_data_4,
  input  logic [7:0]                       tx_data_5,
  input  logic [7:0]                       tx_data_6,
  input  logic [7:0]                       tx_data_7,
  input  logic [7:0]                       tx_data_8,
  input  logic [7:0]                       tx_data_9,
  input  logic [7:0]                       tx_data_10,
  input  logic [7:0]                       tx_data_11,
  input  logic [7:0]                       tx_data_12,
  can_tx_frame_serializer_if.master        bs,
  output logic                             busy,
  output logic                             tx_done,
  output logic                             tx_aborted
);

  localparam int DW = DATA_MAX * 8;
  localparam int CW = $clog2(DW + 40) + 1;
  localparam int NW = $clog2(DATA_MAX + 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, DELIM} state_t;

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      td [13];

  // Decoded view of the live buffer, only loaded at tx_request
  logic            ff;
  logic            rtr_d;
  logic [3:0]      dlc_d;
  logic [28:0]     id_d;
  logic [3:0]      base_d;
  logic [38:0]     hdr_d;
  logic [38:0]     arb_d;
  logic [CW-1:0]   hdr_cnt_d;
  logic [NW-1:0]   n_d;
  logic [DW-1:0]   data_d;
  logic [4:0]      idx;

  // Frame snapshot: header and data are held left-aligned and shifted out MSB first
  logic [38:0]     hdr_sr;
  logic [38:0]     arb_sr;
  logic [DW-1:0]   data_sr;
  logic [NW-1:0]   n_bytes;
  logic [14:0]     crc;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            last_bit;
  logic            crc_fb;
  logic [14:0]     crc_upd;

  assign td[0]  = tx_data_0;
  assign td[1]  = tx_data_1;
  assign td[2]  = tx_data_2;
  assign td[3]  = tx_data_3;
  assign td[4]  = tx_data_4;
  assign td[5]  = tx_data_5;
  assign td[6]  = tx_data_6;
  assign td[7]  = tx_data_7;
  assign td[8]  = tx_data_8;
  assign td[9]  = tx_data_9;
  assign td[10] = tx_data_10;
  assign td[11] = tx_data_11;
  assign td[12] = tx_data_12;

  assign accept   = bs.bit_valid & bs.bit_ready;
  assign last_bit = (cnt == '0);
  assign crc_fb   = bs.tx_bit ^ crc[14];
  assign crc_upd  = {crc[13:0], 1'b0} ^ (crc_fb ? CRC_POLY : 15'h0000);

  // Decode the buffer into header bits, arbitration mask, byte count and payload
  always_comb begin
    ff        = extended_mode & td[0][7];
    rtr_d     = 1'b0;
    dlc_d     = 4'h0;
    id_d      = '0;
    base_d    = 4'd2;
    idx       = '0;
    data_d    = '0;
    if (!extended_mode) begin
      id_d   = {18'b0, td[0], td[1][7:5]};
      rtr_d  = td[1][4];
      dlc_d  = td[1][3:0];
      base_d = 4'd2;
    end else begin
      rtr_d = td[0][6];
      dlc_d = td[0][3:0];
      if (ff) begin
        id_d   = {td[1], td[2], td[3], td[4][7:3]};
        base_d = 4'd5;
      end else begin
        id_d   = {18'b0, td[1], td[2][7:5]};
        base_d = 4'd3;
      end
    end
    // Standard frames count only ID and RTR as arbitration; IDE sits in the control field there
    if (ff) begin
      hdr_d     = {1'b0, id_d[28:18], 2'b11, id_d[17:0], rtr_d, 2'b00, dlc_d};
      arb_d     = {1'b0, {32{1'b1}}, 6'b0};
      hdr_cnt_d = CW'(38);
    end else begin
      hdr_d     = {1'b0, id_d[10:0], rtr_d, 2'b00, dlc_d, 20'b0};
      arb_d     = {1'b0, {12{1'b1}}, 26'b0};
      hdr_cnt_d = CW'(18);
    end
    if (rtr_d) begin
      n_d = '0;
    end else if (int'(dlc_d) > DATA_MAX) begin
      n_d = NW'(DATA_MAX);
    end else begin
      n_d = NW'(dlc_d);
    end
    for (int i = 0; i < DATA_MAX; i++) begin
      idx = 5'(int'(base_d) + i);
      data_d[DW-1-8*i -: 8] = (idx < 5'd13) ? td[idx[3:0]] : 8'h00;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: advance on the last accepted bit of each field; abort wins over everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_request && !abort_tx) state_nxt = HDR;
      HDR:     if (accept && last_bit) state_nxt = (n_bytes != '0) ? DATA : CRC;
      DATA:    if (accept && last_bit) state_nxt = CRC;
      CRC:     if (accept && last_bit) state_nxt = DELIM;
      DELIM:   if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort_tx) begin
      state_nxt = IDLE;
    end
  end

  // Current bit is taken straight from the held field, so it cannot move while stalled
  always_comb begin
    busy              = (state != IDLE);
    bs.bit_valid      = busy;
    bs.in_arbitration = (state == HDR) & arb_sr[38];
    case (state)
      HDR:     bs.tx_bit = hdr_sr[38];
      DATA:    bs.tx_bit = data_sr[DW-1];
      CRC:     bs.tx_bit = crc[14];
      default: bs.tx_bit = 1'b1;
    endcase
  end

  // Snapshot, field shifting, CRC accumulation and completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_sr     <= '0;
      arb_sr     <= '0;
      data_sr    <= '0;
      n_bytes    <= '0;
      crc        <= '0;
      cnt        <= '0;
      tx_done    <= 1'b0;
      tx_aborted <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      tx_aborted <= 1'b0;
      if (state == IDLE) begin
        if (tx_request && !abort_tx) begin
          hdr_sr  <= hdr_d;
          arb_sr  <= arb_d;
          data_sr <= data_d;
          n_bytes <= n_d;
          cnt     <= hdr_cnt_d;
          crc     <= '0;
        end
      end else if (abort_tx) begin
        tx_aborted <= 1'b1;
      end else if (accept) begin
        case (state)
          HDR: begin
            crc    <= crc_upd;
            hdr_sr <= hdr_sr << 1;
            arb_sr <= arb_sr << 1;
            if (last_bit) begin
              cnt <= (n_bytes != '0) ? ((CW'(n_bytes) << 3) - CW'(1)) : CW'(14);
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          DATA: begin
            crc     <= crc_upd;
            data_sr <= data_sr << 1;
            cnt     <= last_bit ? CW'(14) : (cnt - CW'(1));
          end
          CRC: begin
            // Final CRC is no longer accumulated here, only shifted out
            crc <= crc << 1;
            cnt <= last_bit ? '0 : (cnt - CW'(1));
          end
          DELIM: begin
            tx_done <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_tx_frame_serializer.sv
// tb/tb_can_tx_frame_serializer.sv - scoreboard bench for can_tx_frame_serializer
module tb_can_tx_frame_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       extended_mode;
  logic       tx_request;
  logic       abort_tx;
  logic [7:0] td [13];
  logic       busy;
  logic       tx_done;
  logic       tx_aborted;

  can_tx_frame_serializer_if bus();

  can_tx_frame_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .extended_mode (extended_mode),
    .tx_request    (tx_request),
    .abort_tx      (abort_tx),
    .tx_data_0     (td[0]),
    .tx_data_1     (td[1]),
    .tx_data_2     (td[2]),
    .tx_data_3     (td[3]),
    .tx_data_4     (td[4]),
    .tx_data_5     (td[5]),
    .tx_data_6     (td[6]),
    .tx_data_7     (td[7]),
    .tx_data_8     (td[8]),
    .tx_data_9     (td[9]),
    .tx_data_10    (td[10]),
    .tx_data_11    (td[11]),
    .tx_data_12    (td[12]),
    .bs            (bus),
    .busy          (busy),
    .tx_done       (tx_done),
    .tx_aborted    (tx_aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit b;
    bit arb;
    bit last;
  } sb_t;

  sb_t        sb [$];
  int         tests = 0;
  int         fails = 0;
  int         hs_cnt = 0;
  bit         stall_mode = 1'b0;
  bit         abort_expected = 1'b0;
  bit         pending_done = 1'b0;
  bit         stalled_prev = 1'b0;
  logic       prev_bit;
  logic       prev_arb;
  sb_t        e;
  logic [7:0] fd [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: builds the CAN bit list from field rules and pushes it to the scoreboard
  task automatic push_frame(input bit ext, input logic [7:0] d [13], input bit mark_last,
                            output int total, output int hdr_len);
    bit         q [$];
    bit         a [$];
    bit         ff;
    bit         rtr;
    logic [3:0] dlc;
    logic [28:0] id;
    int         base;
    int         n;
    int         c;
    bit         nxt;
    ff = ext && d[0][7];
    if (!ext) begin
      id = {18'b0, d[0], d[1][7:5]}; rtr = d[1][4]; dlc = d[1][3:0]; base = 2;
    end else begin
      rtr = d[0][6]; dlc = d[0][3:0];
      if (ff) begin
        id = {d[1], d[2], d[3], d[4][7:3]}; base = 5;
      end else begin
        id = {18'b0, d[1], d[2][7:5]}; base = 3;
      end
    end
    q.push_back(1'b0); a.push_back(1'b0);
    if (ff) begin
      for (int i = 28; i >= 18; i--) begin q.push_back(id[i]); a.push_back(1'b1); end
      q.push_back(1'b1); a.push_back(1'b1);
      q.push_back(1'b1); a.push_back(1'b1);
      for (int i = 17; i >= 0; i--) begin q.push_back(id[i]); a.push_back(1'b1); end
      q.push_back(rtr); a.push_back(1'b1);
      q.push_back(1'b0); a.push_back(1'b0);
      q.push_back(1'b0); a.push_back(1'b0);
    end else begin
      for (int i = 10; i >= 0; i--) begin q.push_back(id[i]); a.push_back(1'b1); end
      q.push_back(rtr); a.push_back(1'b1);
      q.push_back(1'b0); a.push_back(1'b0);
      q.push_back(1'b0); a.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) begin q.push_back(dlc[i]); a.push_back(1'b0); end
    hdr_len = q.size();
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int j = 0; j < n; j++)
      for (int i = 7; i >= 0; i--) begin q.push_back(d[base+j][i]); a.push_back(1'b0); end
    c = 0;
    foreach (q[k]) begin
      nxt = q[k] ^ c[14];
      c = ((c << 1) & 32'h7FFF) ^ (nxt ? 32'h4599 : 32'h0);
    end
    for (int i = 14; i >= 0; i--) begin q.push_back(c[i]); a.push_back(1'b0); end
    q.push_back(1'b1); a.push_back(1'b0);
    total = q.size();
    for (int k = 0; k < total; k++)
      sb.push_back('{b: q[k], arb: a[k], last: mark_last && (k == total - 1)});
  endtask

  // Downstream ready: constant or random stalls, changed just after each edge
  initial begin
    bus.bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.bit_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops and compares each handshaken bit, checks stall stability and completion pulses
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        stalled_prev = 1'b0;
        pending_done = 1'b0;
      end else begin
        if (pending_done) begin
          check("tx_done pulse", tx_done, 1'b1);
          check("busy after done", busy, 1'b0);
          check("valid after done", bus.bit_valid, 1'b0);
          pending_done = 1'b0;
        end else if (tx_done) begin
          check("spurious tx_done", tx_done, 1'b0);
        end
        if (tx_aborted && !abort_expected) check("spurious tx_aborted", tx_aborted, 1'b0);
        if (stalled_prev && bus.bit_valid) begin
          check("stall tx_bit stable", bus.tx_bit, prev_bit);
          check("stall arb stable", bus.in_arbitration, prev_arb);
        end
        stalled_prev = 1'b0;
        if (bus.bit_valid) begin
          if (bus.bit_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
              check("unexpected bit", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check($sformatf("bit#%0d tx_bit", hs_cnt), bus.tx_bit, e.b);
              check($sformatf("bit#%0d in_arb", hs_cnt), bus.in_arbitration, e.arb);
              if (e.last) pending_done = 1'b1;
            end
          end else begin
            stalled_prev = 1'b1;
            prev_bit = bus.tx_bit;
            prev_arb = bus.in_arbitration;
          end
        end
      end
    end
  end

  task automatic pulse_request();
    @(posedge clk); #1 tx_request = 1'b1;
    @(posedge clk); #1 tx_request = 1'b0;
  endtask

  task automatic run_frame(input bit ext, input logic [7:0] d [13], input bit stall,
                           input int exp_total, input bit poke, input string name);
    int total;
    int hl;
    int base;
    int cyc;
    stall_mode = stall;
    for (int i = 0; i < 13; i++) td[i] = d[i];
    extended_mode = ext;
    push_frame(ext, d, 1'b1, total, hl);
    base = hs_cnt;
    pulse_request();
    check({name, " busy"}, busy, 1'b1);
    if (poke) begin
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) td[i] = 8'($urandom);
      extended_mode = ~ext;
      tx_request = 1'b1;
      @(posedge clk); #1 tx_request = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " finished"}, busy, 1'b0);
    @(posedge clk); #1;
    check({name, " bit count"}, hs_cnt - base, total);
    if (exp_total >= 0) check({name, " frame length"}, hs_cnt - base, exp_total);
    check({name, " scoreboard drained"}, sb.size(), 0);
    check({name, " stays idle"}, busy, 1'b0);
    stall_mode = 1'b0;
  endtask

  task automatic run_abort(input bit ext, input logic [7:0] d [13], input bit at_delim, input string name);
    int total;
    int hl;
    int target;
    int cyc;
    stall_mode = 1'b0;
    for (int i = 0; i < 13; i++) td[i] = d[i];
    extended_mode = ext;
    push_frame(ext, d, 1'b0, total, hl);
    target = at_delim ? hs_cnt + total : hs_cnt + hl + 10;
    pulse_request();
    cyc = 0;
    while (hs_cnt < target && cyc < 2000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check({name, " reached abort point"}, hs_cnt, target);
    abort_expected = 1'b1;
    abort_tx = 1'b1;
    @(posedge clk); #1 abort_tx = 1'b0;
    check({name, " tx_aborted"}, tx_aborted, 1'b1);
    check({name, " valid low"}, bus.bit_valid, 1'b0);
    check({name, " busy low"}, busy, 1'b0);
    check({name, " no done"}, tx_done, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    check({name, " aborted one cycle"}, tx_aborted, 1'b0);
    check({name, " no late done"}, tx_done, 1'b0);
    abort_expected = 1'b0;
  endtask

  task automatic randomize_fd();
    for (int i = 0; i < 13; i++) fd[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    tx_request = 1'b0;
    abort_tx = 1'b0;
    extended_mode = 1'b0;
    for (int i = 0; i < 13; i++) td[i] = 8'h00;
    #12;
    check("reset tx_bit", bus.tx_bit, 1'b1);
    check("reset bit_valid", bus.bit_valid, 1'b0);
    check("reset in_arb", bus.in_arbitration, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset tx_done", tx_done, 1'b0);
    check("reset tx_aborted", tx_aborted, 1'b0);
    @(negedge clk); #2 rst = 1'b1;

    for (int i = 0; i < 13; i++) fd[i] = 8'h00;
    run_frame(1'b0, fd, 1'b0, 35, 1'b0, "basic zero");

    fd[0] = 8'h88; fd[1] = 8'hFF; fd[2] = 8'hFF; fd[3] = 8'hFF; fd[4] = 8'hF8;
    for (int i = 5; i < 13; i++) fd[i] = 8'hA5;
    run_frame(1'b1, fd, 1'b0, 119, 1'b0, "ext max");
    run_frame(1'b1, fd, 1'b1, 119, 1'b0, "ext max stalled");

    randomize_fd(); fd[0] = 8'h4F;
    run_frame(1'b1, fd, 1'b0, 35, 1'b0, "rtr dlc15");
    randomize_fd(); fd[0] = 8'h0F;
    run_frame(1'b1, fd, 1'b1, 99, 1'b0, "dlc15 data");

    // abort together with request in IDLE must neither start nor pulse
    @(posedge clk); #1 tx_request = 1'b1; abort_tx = 1'b1;
    @(posedge clk); #1 tx_request = 1'b0; abort_tx = 1'b0;
    check("idle abort busy", busy, 1'b0);
    check("idle abort valid", bus.bit_valid, 1'b0);
    check("idle abort pulse", tx_aborted, 1'b0);

    randomize_fd(); fd[1] = 8'h08;
    run_abort(1'b0, fd, 1'b0, "abort data bit10");
    randomize_fd();
    run_frame(1'b0, fd, 1'b0, -1, 1'b0, "after abort");
    randomize_fd(); fd[1] = 8'h03;
    run_abort(1'b0, fd, 1'b1, "abort delim");
    randomize_fd();
    run_frame(1'b1, fd, 1'b1, -1, 1'b0, "after delim abort");

    randomize_fd(); fd[1] = 8'h28;
    run_frame(1'b0, fd, 1'b1, 99, 1'b1, "request while busy");

    // asynchronous reset between clock edges in the middle of a frame
    randomize_fd(); fd[0] = 8'h88;
    for (int i = 0; i < 13; i++) td[i] = fd[i];
    extended_mode = 1'b1;
    begin
      int total;
      int hl;
      push_frame(1'b1, fd, 1'b0, total, hl);
    end
    pulse_request();
    repeat (30) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async rst tx_bit", bus.tx_bit, 1'b1);
    check("async rst valid", bus.bit_valid, 1'b0);
    check("async rst in_arb", bus.in_arbitration, 1'b0);
    check("async rst busy", busy, 1'b0);
    check("async rst done", tx_done, 1'b0);
    check("async rst aborted", tx_aborted, 1'b0);
    sb.delete();
    @(negedge clk); #2 rst = 1'b1;
    randomize_fd();
    run_frame(1'b1, fd, 1'b0, -1, 1'b0, "after reset");

    for (int r = 0; r < 25; r++) begin
      randomize_fd();
      run_frame(1'($urandom), fd, 1'($urandom), -1, 1'b0, $sformatf("random %0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
